// File: rtl/rv_alu_pkg.sv
// Shared ALU definitions: default datapath width and operation codes.
package rv_alu_pkg;

  localparam int ALU_WIDTH = 64;
  localparam int ALU_OP_W  = 5;

  localparam logic [ALU_OP_W-1:0] ALU_ADD    = 5'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB    = 5'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND    = 5'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR     = 5'd3;
  localparam logic [ALU_OP_W-1:0] ALU_XOR    = 5'd4;
  localparam logic [ALU_OP_W-1:0] ALU_SLL    = 5'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SRL    = 5'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SRA    = 5'd7;
  localparam logic [ALU_OP_W-1:0] ALU_SLT    = 5'd8;
  localparam logic [ALU_OP_W-1:0] ALU_SLTU   = 5'd9;
  localparam logic [ALU_OP_W-1:0] ALU_MUL    = 5'd10;
  localparam logic [ALU_OP_W-1:0] ALU_MULH   = 5'd11;
  localparam logic [ALU_OP_W-1:0] ALU_MULHSU = 5'd12;
  localparam logic [ALU_OP_W-1:0] ALU_MULHU  = 5'd13;
  localparam logic [ALU_OP_W-1:0] ALU_DIV    = 5'd14;
  localparam logic [ALU_OP_W-1:0] ALU_DIVU   = 5'd15;
  localparam logic [ALU_OP_W-1:0] ALU_REM    = 5'd16;
  localparam logic [ALU_OP_W-1:0] ALU_REMU   = 5'd17;

endpackage

// File: rtl/rv_alu_muldiv.sv
// Combinational multiply/divide unit: mul, mulh*, div(u), rem(u).
module rv_alu_muldiv
  import rv_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [WIDTH-1:0]    result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [2*WIDTH-1:0] a_ext, b_ext, prod;
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   b_sdiv, b_udiv;
  logic [WIDTH-1:0]   quo_s, rem_s, quo_u, rem_u;

  // One shared 2W-bit multiplier; operand extension selects the signedness.
  // Modulo 2^(2W), sign-extended operands give the true signed product bits.
  always_comb begin
    a_ext = {{WIDTH{a[WIDTH-1] & (op != ALU_MULHU)}}, a};
    b_ext = {{WIDTH{b[WIDTH-1] & (op == ALU_MULH)}}, b};
    prod  = a_ext * b_ext;
  end

  // Dividers see a safe divisor; substituting 1 on signed overflow yields
  // quotient = a and remainder = 0, exactly the required overflow answers.
  always_comb begin
    div_zero = (b == '0);
    div_ovf  = (a == MIN_NEG) && (b == '1);
    b_sdiv   = (div_zero || div_ovf) ? ONE : b;
    b_udiv   = div_zero ? ONE : b;
    quo_s    = $unsigned($signed(a) / $signed(b_sdiv));
    rem_s    = $unsigned($signed(a) % $signed(b_sdiv));
    quo_u    = a / b_udiv;
    rem_u    = a % b_udiv;
  end

  // Result select, with divide-by-zero overrides.
  always_comb begin
    result = '0;
    case (op)
      ALU_MUL:    result = prod[WIDTH-1:0];
      ALU_MULH,
      ALU_MULHSU,
      ALU_MULHU:  result = prod[2*WIDTH-1:WIDTH];
      ALU_DIV:    result = div_zero ? '1 : quo_s;
      ALU_DIVU:   result = div_zero ? '1 : quo_u;
      ALU_REM:    result = div_zero ? a  : rem_s;
      ALU_REMU:   result = div_zero ? a  : rem_u;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/rv_alu.sv
// Single-cycle RV ALU: arithmetic, logic, shifts, compares, mul/div,
// with a registered result and a registered operand-equality flag.
module rv_alu
  import rv_alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [WIDTH-1:0]    result,
  output logic                isEqual
);

  localparam int SH_W = $clog2(WIDTH);

  logic [WIDTH-1:0]        md_result;
  logic [WIDTH-1:0]        alu_next;
  logic [SH_W-1:0]         shamt;
  logic signed [WIDTH-1:0] a_s;

  rv_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .a      (a),
    .b      (b),
    .op     (op),
    .result (md_result)
  );

  // Next-result select; unassigned op codes produce zero.
  always_comb begin
    alu_next = '0;
    shamt    = b[SH_W-1:0];
    a_s      = $signed(a);
    case (op)
      ALU_ADD:  alu_next = a + b;
      ALU_SUB:  alu_next = a - b;
      ALU_AND:  alu_next = a & b;
      ALU_OR:   alu_next = a | b;
      ALU_XOR:  alu_next = a ^ b;
      ALU_SLL:  alu_next = a << shamt;
      ALU_SRL:  alu_next = a >> shamt;
      ALU_SRA:  alu_next = $unsigned(a_s >>> shamt);
      ALU_SLT:  alu_next[0] = ($signed(a) < $signed(b));
      ALU_SLTU: alu_next[0] = (a < b);
      ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU:
                alu_next = md_result;
      default:  alu_next = '0;
    endcase
  end

  // Output register; reset clears both outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      result  <= '0;
      isEqual <= 1'b0;
    end else begin
      result  <= alu_next;
      isEqual <= (a == b);
    end
  end

endmodule

// File: tb/tb_rv_alu.sv
// Directed bench for rv_alu: hand-computed vectors, one op per cycle.
module tb_rv_alu;
  import rv_alu_pkg::*;

  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] MIN  = 64'h8000_0000_0000_0000;

  logic        clk;
  logic        rst;
  logic [63:0] a, b, result;
  logic [4:0]  op;
  logic        isEqual;

  int total = 0;
  int bad   = 0;

  logic [63:0] prev_res;
  logic        prev_eq;
  logic        prev_valid = 1'b0;

  rv_alu #(.WIDTH(64)) dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .op      (op),
    .result  (result),
    .isEqual (isEqual)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive on the falling edge, confirm the previous output is still held,
  // then check the new output just after the rising edge.
  task automatic step(input string tag, input logic r, input logic [63:0] ta,
                      input logic [63:0] tb_, input logic [4:0] top,
                      input logic [63:0] exp_res, input logic exp_eq);
    @(negedge clk);
    rst = r; a = ta; b = tb_; op = top;
    #1;
    if (prev_valid) begin
      total++;
      assert (result === prev_res && isEqual === prev_eq) else begin
        bad++;
        $error("FAIL %s_hold got res=%h eq=%b exp res=%h eq=%b", tag, result, isEqual, prev_res, prev_eq);
      end
    end
    @(posedge clk);
    #1;
    total++;
    assert (result === exp_res) else begin
      bad++;
      $error("FAIL %s_res got=%h exp=%h", tag, result, exp_res);
    end
    total++;
    assert (isEqual === exp_eq) else begin
      bad++;
      $error("FAIL %s_eq got=%b exp=%b", tag, isEqual, exp_eq);
    end
    prev_res   = exp_res;
    prev_eq    = exp_eq;
    prev_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; a = '0; b = '0; op = '0;
    // reset with a live-looking operation on the inputs
    step("rst",      1'b1, 64'd5,  64'd5,  ALU_ADD,    64'd0, 1'b0);
    step("add",      1'b0, 64'd5,  64'd5,  ALU_ADD,    64'd10, 1'b1);
    step("sub",      1'b0, 64'd66, 64'd11, ALU_SUB,    64'd55, 1'b0);
    step("and",      1'b0, 64'd5,  64'd6,  ALU_AND,    64'd4, 1'b0);
    step("or",       1'b0, 64'd5,  64'd6,  ALU_OR,     64'd7, 1'b0);
    step("xor",      1'b0, 64'd6,  64'd2,  ALU_XOR,    64'd4, 1'b0);
    step("add_wrap", 1'b0, ONES,   64'd1,  ALU_ADD,    64'd0, 1'b0);
    step("sub_wrap", 1'b0, 64'd0,  64'd1,  ALU_SUB,    ONES, 1'b0);
    step("sll",      1'b0, 64'd1,  64'd3,  ALU_SLL,    64'd8, 1'b0);
    step("sll63",    1'b0, 64'd1,  64'd63, ALU_SLL,    MIN, 1'b0);
    step("srl",      1'b0, 64'd8,  64'd2,  ALU_SRL,    64'd2, 1'b0);
    step("srl_amt",  1'b0, 64'd8,  64'd65, ALU_SRL,    64'd4, 1'b0);
    step("sra",      1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd2, ALU_SRA, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    step("sra63",    1'b0, MIN,    64'd63, ALU_SRA,    ONES, 1'b0);
    step("srl63",    1'b0, MIN,    64'd63, ALU_SRL,    64'd1, 1'b0);
    step("slt",      1'b0, ONES,   64'd9,  ALU_SLT,    64'd1, 1'b0);
    step("sltu",     1'b0, ONES,   64'd9,  ALU_SLTU,   64'd0, 1'b0);
    step("mul",      1'b0, 64'd6,  64'd5,  ALU_MUL,    64'd30, 1'b0);
    step("mulh",     1'b0, 64'd6,  64'd5,  ALU_MULH,   64'd0, 1'b0);
    step("mulhsu",   1'b0, 64'd6,  64'd5,  ALU_MULHSU, 64'd0, 1'b0);
    step("mulhu",    1'b0, 64'd6,  64'd5,  ALU_MULHU,  64'd0, 1'b0);
    step("div",      1'b0, 64'd6,  64'd5,  ALU_DIV,    64'd1, 1'b0);
    step("divu",     1'b0, 64'd6,  64'd5,  ALU_DIVU,   64'd1, 1'b0);
    step("rem",      1'b0, 64'd6,  64'd5,  ALU_REM,    64'd1, 1'b0);
    step("remu",     1'b0, 64'd6,  64'd5,  ALU_REMU,   64'd1, 1'b0);
    step("mulhu_m1", 1'b0, ONES,   ONES,   ALU_MULHU,  64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    step("mulh_m1",  1'b0, ONES,   ONES,   ALU_MULH,   64'd0, 1'b1);
    step("mulhsu_m1",1'b0, ONES,   ONES,   ALU_MULHSU, ONES, 1'b1);
    step("mul_m1",   1'b0, ONES,   ONES,   ALU_MUL,    64'd1, 1'b1);
    step("div0",     1'b0, 64'd7,  64'd0,  ALU_DIV,    ONES, 1'b0);
    step("rem0",     1'b0, 64'd7,  64'd0,  ALU_REM,    64'd7, 1'b0);
    step("divu0",    1'b0, 64'd7,  64'd0,  ALU_DIVU,   ONES, 1'b0);
    step("remu0",    1'b0, 64'd7,  64'd0,  ALU_REMU,   64'd7, 1'b0);
    step("div_ovf",  1'b0, MIN,    ONES,   ALU_DIV,    MIN, 1'b0);
    step("rem_ovf",  1'b0, MIN,    ONES,   ALU_REM,    64'd0, 1'b0);
    step("divu_big", 1'b0, MIN,    ONES,   ALU_DIVU,   64'd0, 1'b0);
    step("remu_big", 1'b0, MIN,    ONES,   ALU_REMU,   MIN, 1'b0);
    step("div_neg",  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALU_DIV, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0);
    step("rem_neg",  1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ALU_REM, ONES, 1'b0);
    step("op20",     1'b0, 64'd3,  64'd3,  5'd20,      64'd0, 1'b1);
    step("op31",     1'b0, 64'd1,  64'd2,  5'd31,      64'd0, 1'b0);
    step("op18",     1'b0, 64'd9,  64'd9,  5'd18,      64'd0, 1'b1);
    step("pre_rst",  1'b0, 64'd20, 64'd22, ALU_ADD,    64'd42, 1'b0);
    step("rst2",     1'b1, 64'd4,  64'd4,  ALU_OR,     64'd0, 1'b0);
    step("post_rst", 1'b0, 64'd2,  64'd2,  ALU_SUB,    64'd0, 1'b1);
    step("post_rst2",1'b0, 64'd9,  64'd3,  ALU_MUL,    64'd27, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
